// File: rtl/counter_pkg.sv
// Shared defaults and the count type for consumers of the free-running counter.
// Consumers that keep the default width can hold a count in count_t.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT       = 8;
    localparam int COUNTER_RESET_VALUE_DEFAULT = 0;

    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter.sv
// Free-running WIDTH-bit up-counter with an all-ones decode and a registered wrap pulse.
// counter_checker holds the temporal properties and can also be bound on its own.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = COUNTER_WIDTH_DEFAULT,
    parameter int RESET_VALUE = COUNTER_RESET_VALUE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] value,
    output logic             at_max,
    output logic             wrapped
);

    logic [WIDTH-1:0] r_value;
    logic             r_wrapped;
    logic             w_at_max;

    assign w_at_max = (r_value == '1);

    // Reset wins even at all-ones, so a reset on the terminal count never pulses wrapped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value   <= WIDTH'(RESET_VALUE);
            r_wrapped <= 1'b0;
        end else begin
            r_value   <= r_value + WIDTH'(1);
            r_wrapped <= w_at_max;
        end
    end

    assign value   = r_value;
    assign at_max  = w_at_max;
    assign wrapped = r_wrapped;

`ifndef SYNTHESIS
    counter_checker #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_checker (
        .clk     (clk),
        .reset   (reset),
        .value   (r_value),
        .wrapped (r_wrapped)
    );
`endif

endmodule : counter

// Outputs are meaningless until the first reset, so properties stay disabled until one is seen.
module counter_checker #(
    parameter int WIDTH       = 8,
    parameter int RESET_VALUE = 0
) (
    input logic             clk,
    input logic             reset,
    input logic [WIDTH-1:0] value,
    input logic             wrapped
);

    logic r_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b1;
        end
    end

    a_increment : assert property (@(posedge clk) disable iff (!r_armed)
        !reset |=> (value == WIDTH'($past(value) + WIDTH'(1))));

    a_reset_load : assert property (@(posedge clk)
        reset |=> ((value == WIDTH'(RESET_VALUE)) && !wrapped));

    a_wrap_pulse : assert property (@(posedge clk) disable iff (!r_armed)
        wrapped |=> !wrapped);

endmodule : counter_checker

// File: tb/tb_counter.sv
// Randomized/directed bench for two counter instances (8-bit from 0, 4-bit from 5) with a queue scoreboard.
module tb_counter;

    typedef struct packed {
        logic [31:0] v;
        logic        m;
        logic        w;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] value_a;
    logic       at_max_a;
    logic       wrapped_a;
    logic [3:0] value_b;
    logic       at_max_b;
    logic       wrapped_b;

    counter #(.WIDTH(8), .RESET_VALUE(0)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .value   (value_a),
        .at_max  (at_max_a),
        .wrapped (wrapped_a)
    );

    counter #(.WIDTH(4), .RESET_VALUE(5)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .value   (value_b),
        .at_max  (at_max_b),
        .wrapped (wrapped_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   exp_wraps = 0;
    int   seen_wraps = 0;
    bit   stim_done = 1'b0;

    // Reference state: a plain integer count; unknown until the first reset.
    longint unsigned cnt_a = 0;
    longint unsigned cnt_b = 0;
    bit              known = 1'b0;

    function automatic void model_step(input int w, input longint unsigned rv, input bit rst,
                                       inout longint unsigned cnt, output exp_t e);
        longint unsigned modulus;
        modulus = 64'd1 << w;
        if (rst) begin
            cnt = rv;
            e.w = 1'b0;
        end else begin
            e.w = (cnt == modulus - 1);
            cnt = (cnt + 1) % modulus;
        end
        e.v = 32'(cnt);
        e.m = (cnt == modulus - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive reset for the coming edge and record its expected outcome.
    task automatic cycle(input bit rst, input bit glitch);
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        #1;
        reset = rst;
        if (rst) known = 1'b1;
        if (known) begin
            model_step(8, 0, rst, cnt_a, ea);
            model_step(4, 5, rst, cnt_b, eb);
            q_a.push_back(ea);
            q_b.push_back(eb);
            if (ea.w) exp_wraps++;
        end
        if (glitch && !rst) begin
            #1 reset = 1'b1;
            #2 reset = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    // Monitor: pops one expectation per edge and compares away from the active edge.
    initial begin
        exp_t ea;
        exp_t eb;
        forever begin
            @(negedge clk);
            if (q_a.size() != 0 && q_b.size() != 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                check("a.value",   {24'b0, value_a}, ea.v);
                check("a.at_max",  {31'b0, at_max_a}, {31'b0, ea.m});
                check("a.wrapped", {31'b0, wrapped_a}, {31'b0, ea.w});
                check("b.value",   {28'b0, value_b}, eb.v);
                check("b.at_max",  {31'b0, at_max_b}, {31'b0, eb.m});
                check("b.wrapped", {31'b0, wrapped_b}, {31'b0, eb.w});
                if (wrapped_a) seen_wraps++;
                $display("t=%0t a=%02h/%0b/%0b b=%01h/%0b/%0b", $time,
                         value_a, at_max_a, wrapped_a, value_b, at_max_b, wrapped_b);
            end
        end
    end

    initial begin
        reset = 1'b0;
        run(1);                     // power-up edge, outputs not checked
        cycle(1'b1, 1'b0);          // first reset
        run(3);
        cycle(1'b1, 1'b0);          // second reset pulse
        run(10);
        repeat (5) cycle(1'b1, 1'b0);
        run(2);
        cycle(1'b1, 1'b0);
        run(255);                   // reaches 0xFF
        run(2);                     // wrap to 0x00, then 0x01
        cycle(1'b1, 1'b0);
        run(255);                   // 0xFF again
        cycle(1'b1, 1'b0);          // reset on the terminal count: no wrap pulse
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 600; i++) cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0));
        run(1);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while ((q_a.size() != 0 || q_b.size() != 0) && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        check("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);
        check("wrap_pulse_count", 32'(seen_wraps), 32'(exp_wraps));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_counter
